mlp_mac_pipe: RTL and testbench
===============================

Name: mlp_mac_pipe

Overview:
Parametrised pipelined signed multiply/multiply-accumulate unit for the MLP datapath, generalising the fixed 14x14 DSP multiplier. It has configurable operand/result widths, pipeline depth and fixed-point scaling. It adds valid tracking, a per-beat dot-product accumulation mode with last-beat flush, round-half-up and output saturation. It sits between the weight/activation fetch and the activation-function stage of each neuron.

Parameters:
DIN_W, 14, signed width of din0/din1 (2..27)
DOUT_W, 14, signed width of dout (2..ACC_W)
ACC_W, 32, signed accumulator width (>= 2*DIN_W)
FRAC_BITS, 0, right shift applied to the final sum (0..2*DIN_W-1)
MUL_STAGES, 3, product pipeline registers (>= 2): operand regs, product reg, MUL_STAGES-2 extra delay regs

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
ce  in  1  clock enable; 0 freezes every register
in_valid  in  1  din0/din1/in_last/acc_mode are a beat
in_last  in  1  final beat of an accumulation sequence (mode 1 only)
acc_mode  in  1  0 = single multiply, 1 = accumulate; sampled per beat
din0  in  DIN_W  signed operand A
din1  in  DIN_W  signed operand B
dout  out  DOUT_W  signed rounded/saturated result
dout_valid  out  1  dout holds a new result (one-cycle pulse per result while ce=1)
sat_flag  out  1  result was clipped; qualified by dout_valid

Behaviour:
- Reset (async, active-high): all pipeline, accumulator and output registers clear to 0. dout=0, dout_valid=0, sat_flag=0. Beats in flight are discarded and a partial accumulation is lost.
- ce=0: no register changes, including dout/dout_valid/sat_flag, which hold their values. Inputs are ignored that cycle. No beat is dropped or duplicated across stalls.
- Pipeline: valid, last and mode travel alongside the data through MUL_STAGES stages. The product is the full 2*DIN_W signed product, sign-extended to ACC_W.
- Final stage (registered output), taking beat p from the product pipeline:
  mode 0: s = p. The accumulator is untouched.
  mode 1, not last: acc <= satACC(acc + p). No output.
  mode 1, last: s = satACC(acc + p), and acc <= 0 in the same cycle.
- Result for a produced s:
  if FRAC_BITS>0, r = (s + 2^(FRAC_BITS-1)) >>> FRAC_BITS (round half up); otherwise r = s.
  dout = r clipped to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1].
  sat_flag=1 if a clip occurred in either the accumulator or the output.
  dout_valid=1.
- Accumulator saturation: satACC clips to ACC_W signed range. An accumulator clip is sticky until the sequence flush and is reported on that flush's sat_flag.
- Latency: MUL_STAGES+1 enabled cycles from the in_valid beat to dout_valid. For a mode-1 sequence, the same latency is measured from the last beat.
- Throughput: one beat per enabled cycle, no backpressure. Back-to-back sequences are allowed: the flush clear and the first beat of the next sequence resolve as acc = 0 + p.
- A mode-0 beat interleaved inside a mode-1 sequence produces its own output and leaves acc unchanged.
- in_last on a mode-0 beat is ignored.
- Cycles without in_valid produce dout_valid=0. dout holds its previous value.

Optional Feature:
MLP_MAC_RELU_EN: when defined, after rounding/saturation any negative result is output as 0. ReLU clamping does not set sat_flag, but a prior saturation still does. When undefined, results are signed as described above. Latency is identical in both builds.

Test Plan:
1. Defaults, mode 0, din0=100, din1=50 -> 4 cycles later dout=5000, dout_valid=1 for one cycle, sat_flag=0.
2. Mode 0, 200*100 -> dout=8191, sat_flag=1. Then -200*100 -> dout=-8192, sat_flag=1 (with RELU_EN: dout=0, sat_flag=1).
3. Mode 1 beats (10,20),(30,40),(-5,6,last), immediately followed by (2,3,last) -> exactly two outputs: 1370, then 6. No dout_valid for the non-last beats.
4. FRAC_BITS=4: 3*7 -> dout=1; -3*7 -> dout=-1; 1*8 -> dout=1 (half rounds up).
5. Beat issued, ce dropped for 3 cycles mid-pipeline -> dout_valid appears after exactly 4 enabled cycles, and dout/dout_valid are frozen during the stall.
6. Mode 1, two non-last beats (100,100), reset asserted, then new sequence (1,1,last) -> dout=1, confirming the accumulator was cleared with no stale output.

Source files
------------

// File: rtl/mlp_mac_pipe.sv
// mlp_mac_pipe: pipelined signed multiply / multiply-accumulate for the MLP datapath.
//
// Each beat's product is formed in a MUL_STAGES-deep pipeline. A registered final
// stage then either emits the product directly (acc_mode=0) or folds it into a
// saturating accumulator (acc_mode=1). On the in_last beat it flushes the running sum.
// Each result is rounded half-up by FRAC_BITS and clipped to DOUT_W.
//
// Build option: define MLP_MAC_RELU_EN to clamp negative results to 0 after
// rounding/saturation. The clamp does not set sat_flag, and latency is unchanged.
//
// Handshake: valid-only, with no backpressure. A beat is transferred on every
// rising clk edge where ce=1 and in_valid=1. A result is presented on every edge
// where ce=1 that sets dout_valid=1. dout_valid lasts for one enabled cycle, and
// dout/sat_flag hold their values until the next result. While ce=0 every register
// holds its value.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   ce         clock enable for every register
//   in_valid   din0/din1/in_last/acc_mode form a beat
//   in_last    last beat of an accumulation sequence (only honoured when acc_mode=1)
//   acc_mode   0 = single multiply, 1 = accumulate
//   din0/din1  signed operands
//   dout       signed rounded/saturated result
//   dout_valid one-cycle pulse per result
//   sat_flag   result was clipped (accumulator or output), qualified by dout_valid
module mlp_mac_pipe #(
  parameter int DIN_W      = 14,
  parameter int DOUT_W     = 14,
  parameter int ACC_W      = 32,
  parameter int FRAC_BITS  = 0,
  parameter int MUL_STAGES = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic                     acc_mode,
  input  logic signed [DIN_W-1:0]  din0,
  input  logic signed [DIN_W-1:0]  din1,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     dout_valid,
  output logic                     sat_flag
);

  localparam int PW  = 2 * DIN_W;
  localparam int DLY = MUL_STAGES - 1;  // product register plus extra delay registers

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Output clip bounds, sign-extended to the one-bit-wider rounding width.
  localparam logic signed [ACC_W:0] OUT_MAX_W = {{(ACC_W-DOUT_W+2){1'b0}}, {(DOUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN_W = {{(ACC_W-DOUT_W+2){1'b1}}, {(DOUT_W-1){1'b0}}};
  localparam logic signed [DOUT_W-1:0] OUT_MAX = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic signed [DOUT_W-1:0] OUT_MIN = {1'b1, {(DOUT_W-1){1'b0}}};

  // Rounding constant 2^(FRAC_BITS-1). It evaluates to 0 when FRAC_BITS is 0.
  localparam logic [ACC_W:0] HALF = ({{ACC_W{1'b0}}, 1'b1} << FRAC_BITS) >> 1;

  // Product pipeline. Bit 0 of the side-band vectors belongs to the operand stage.
  // Bit k belongs to p_pipe[k-1].
  logic signed [DIN_W-1:0] a_q, b_q;
  logic [MUL_STAGES-1:0]   v_pipe, l_pipe, m_pipe;
  logic signed [PW-1:0]    p_pipe [DLY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      v_pipe <= '0;
      l_pipe <= '0;
      m_pipe <= '0;
      for (int i = 0; i < DLY; i++) p_pipe[i] <= '0;
    end else if (ce) begin
      a_q       <= din0;
      b_q       <= din1;
      v_pipe    <= {v_pipe[MUL_STAGES-2:0], in_valid};
      l_pipe    <= {l_pipe[MUL_STAGES-2:0], in_last};
      m_pipe    <= {m_pipe[MUL_STAGES-2:0], acc_mode};
      p_pipe[0] <= PW'(a_q) * PW'(b_q);
      for (int i = 1; i < DLY; i++) p_pipe[i] <= p_pipe[i-1];
    end
  end

  logic                    v_f, l_f, m_f;
  logic signed [PW-1:0]    p_f;
  assign v_f = v_pipe[MUL_STAGES-1];
  assign l_f = l_pipe[MUL_STAGES-1];
  assign m_f = m_pipe[MUL_STAGES-1];
  assign p_f = p_pipe[DLY-1];

  // Final-stage arithmetic
  logic signed [ACC_W-1:0]  acc;
  logic                     acc_sticky;
  logic signed [ACC_W:0]    p_wide, sum_wide, s_wide, rnd, r;
  logic signed [ACC_W-1:0]  acc_next;
  logic                     acc_ovf, out_clip, sat_res;
  logic signed [DOUT_W-1:0] res;

  always_comb begin
    p_wide   = (ACC_W+1)'(p_f);
    sum_wide = (ACC_W+1)'(acc) + p_wide;
    // One guard bit is enough because |p| never exceeds the ACC_W range.
    acc_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    acc_next = sum_wide[ACC_W-1:0];
    if (acc_ovf) acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;

    s_wide = m_f ? (ACC_W+1)'(acc_next) : p_wide;
    rnd    = s_wide + $signed(HALF);
    r      = rnd >>> FRAC_BITS;

    out_clip = 1'b0;
    res      = r[DOUT_W-1:0];
    if (r > OUT_MAX_W) begin
      res      = OUT_MAX;
      out_clip = 1'b1;
    end else if (r < OUT_MIN_W) begin
      res      = OUT_MIN;
      out_clip = 1'b1;
    end
`ifdef MLP_MAC_RELU_EN
    if (res[DOUT_W-1]) res = '0;
`else
`endif
    // A mode-0 result never reports accumulator clipping.
    sat_res = out_clip | (m_f & (acc_ovf | acc_sticky));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      acc_sticky <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sat_flag   <= 1'b0;
    end else if (ce) begin
      dout_valid <= 1'b0;
      if (v_f) begin
        if (!m_f) begin
          dout       <= res;
          sat_flag   <= sat_res;
          dout_valid <= 1'b1;
        end else if (!l_f) begin
          acc        <= acc_next;
          acc_sticky <= acc_sticky | acc_ovf;
        end else begin
          // Flush: emit the sum and restart from zero, so a following beat sees acc = 0.
          dout       <= res;
          sat_flag   <= sat_res;
          dout_valid <= 1'b1;
          acc        <= '0;
          acc_sticky <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mlp_mac_pipe.sv
// Testbench for mlp_mac_pipe. Two instances share the stimulus: default parameters
// and FRAC_BITS=4. A spec-level arithmetic model predicts each instance's results
// and the enabled-cycle count at which each result must appear.
module tb_mlp_mac_pipe;

  localparam int W = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, ce, in_valid, in_last, acc_mode;
  logic signed [W-1:0] din0, din1;
  logic signed [W-1:0] dout0, dout1;
  logic dout_valid0, dout_valid1, sat0, sat1;

  mlp_mac_pipe dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
    .acc_mode(acc_mode), .din0(din0), .din1(din1),
    .dout(dout0), .dout_valid(dout_valid0), .sat_flag(sat0)
  );

  mlp_mac_pipe #(.FRAC_BITS(4)) dut_f (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
    .acc_mode(acc_mode), .din0(din0), .din1(din1),
    .dout(dout1), .dout_valid(dout_valid1), .sat_flag(sat1)
  );

  // ---------------- reference model / scoreboard state ----------------
  localparam longint ACC_MAX_M = (longint'(1) <<< 31) - 1;
  localparam longint ACC_MIN_M = -(longint'(1) <<< 31);

  longint m_acc;
  bit     m_sticky;
  int     en_cnt;                 // enabled clock edges seen so far
  int     due_q[$];               // en_cnt value at which each result must show
  logic [W:0] exp_q0[$];          // {sat, dout} for the FRAC_BITS=0 instance
  logic [W:0] exp_q1[$];          // {sat, dout} for the FRAC_BITS=4 instance
  logic [W:0] cur0, cur1;         // most recent result (held by the DUT)
  int     cur_cnt;
  int     n_cmp, n_err;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint sat_acc(input longint x, output bit c);
    c = 1'b0;
    if (x > ACC_MAX_M) begin x = ACC_MAX_M; c = 1'b1; end
    else if (x < ACC_MIN_M) begin x = ACC_MIN_M; c = 1'b1; end
    return x;
  endfunction

  function automatic logic [W:0] make_out(input longint s, input int frac, input bit pre);
    longint r;
    bit clip;
    logic [W-1:0] d;
    if (frac > 0) r = (s + (longint'(1) <<< (frac - 1))) >>> frac;
    else          r = s;
    clip = 1'b0;
    if (r > 8191) begin r = 8191; clip = 1'b1; end
    else if (r < -8192) begin r = -8192; clip = 1'b1; end
`ifdef MLP_MAC_RELU_EN
    if (r < 0) r = 0;
`endif
    d = r[W-1:0];
    return {pre | clip, d};
  endfunction

  task automatic push_result(input longint s, input bit pre);
    due_q.push_back(en_cnt + 4);
    exp_q0.push_back(make_out(s, 0, pre));
    exp_q1.push_back(make_out(s, 4, pre));
  endtask

  task automatic model_beat(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                            input bit l, input bit m);
    longint p, s;
    bit c;
    p = longint'(a) * longint'(b);
    if (!m) begin
      push_result(p, 1'b0);
    end else if (!l) begin
      m_acc = sat_acc(m_acc + p, c);
      m_sticky = m_sticky | c;
    end else begin
      s = sat_acc(m_acc + p, c);
      push_result(s, c | m_sticky);
      m_acc = 0;
      m_sticky = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int v, input int l, input int m, input int a, input int b, input int c);
    logic signed [W-1:0] ta, tb;
    ta = W'(a);
    tb = W'(b);
    in_valid = (v != 0);
    in_last  = (l != 0);
    acc_mode = (m != 0);
    din0     = ta;
    din1     = tb;
    ce       = (c != 0);
    if (c != 0 && v != 0 && !reset) model_beat(ta, tb, l != 0, m != 0);
    @(posedge clk);
    if (c != 0) en_cnt++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_acc = 0;
    m_sticky = 1'b0;
    due_q.delete();
    exp_q0.delete();
    exp_q1.delete();
    cur0 = '0;
    cur1 = '0;
    cur_cnt = -1;
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    reset = 1'b0;
  endtask

  // ---------------- scoreboard: checks every cycle on the falling edge ----------------
  always @(negedge clk) begin
    if (due_q.size() > 0 && due_q[0] == en_cnt && cur_cnt != en_cnt) begin
      void'(due_q.pop_front());
      cur0 = exp_q0.pop_front();
      cur1 = exp_q1.pop_front();
      cur_cnt = en_cnt;
    end
    chk("valid_f0", 32'(dout_valid0), 32'(cur_cnt == en_cnt));
    chk("dout_f0",  32'($signed(dout0)), 32'($signed(cur0[W-1:0])));
    chk("sat_f0",   32'(sat0), 32'(cur0[W]));
    chk("valid_f4", 32'(dout_valid1), 32'(cur_cnt == en_cnt));
    chk("dout_f4",  32'($signed(dout1)), 32'($signed(cur1[W-1:0])));
    chk("sat_f4",   32'(sat1), 32'(cur1[W]));
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    n_cmp = 0; n_err = 0; en_cnt = 0; cur_cnt = -1;
    cur0 = '0; cur1 = '0; m_acc = 0; m_sticky = 1'b0;
    reset = 1'b1; ce = 1'b0; in_valid = 1'b0; in_last = 1'b0; acc_mode = 1'b0;
    din0 = '0; din1 = '0;

    do_reset();
    chk("reset_dout",  32'($signed(dout0)), 0);
    chk("reset_valid", 32'(dout_valid0), 0);
    chk("reset_sat",   32'(sat0), 0);

    // Single multiply
    drive(1, 0, 0, 100, 50, 1);
    idle(6);
    // Output saturation, both signs
    drive(1, 0, 0, 200, 100, 1);
    drive(1, 0, 0, -200, 100, 1);
    idle(6);
    // Dot product, then a back-to-back single-beat sequence
    drive(1, 0, 1, 10, 20, 1);
    drive(1, 0, 1, 30, 40, 1);
    drive(1, 1, 1, -5, 6, 1);
    drive(1, 1, 1, 2, 3, 1);
    idle(6);
    // Rounding cases, including half-up
    drive(1, 0, 0, 3, 7, 1);
    drive(1, 0, 0, -3, 7, 1);
    drive(1, 0, 0, 1, 8, 1);
    idle(6);
    // Stall in mid-pipeline
    drive(1, 0, 0, 77, -9, 1);
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 55, 55, 0);
    idle(6);
    // Stall while a result is being presented
    drive(1, 0, 0, -40, 41, 1);
    idle(3);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
    idle(4);
    // Mode-0 beat inside a sequence, with in_last ignored on it
    drive(1, 0, 1, 5, 5, 1);
    drive(1, 1, 0, 7, 7, 1);
    drive(1, 1, 1, 2, 2, 1);
    idle(6);
    // Accumulator saturation in both directions
    for (int i = 0; i < 40; i++) drive(1, 0, 1, -8192, -8192, 1);
    drive(1, 1, 1, -8192, 8191, 1);
    for (int i = 0; i < 40; i++) drive(1, 0, 1, -8192, 8191, 1);
    drive(1, 1, 1, 1, 1, 1);
    idle(6);
    // Reset during an accumulation
    drive(1, 0, 1, 100, 100, 1);
    drive(1, 0, 1, 100, 100, 1);
    do_reset();
    drive(1, 1, 1, 1, 1, 1);
    idle(6);

    // Randomized traffic with random stalls
    for (int i = 0; i < 400; i++) begin
      drive(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 1)),
            int'($signed(W'($urandom_range(0, 16383)))),
            int'($signed(W'($urandom_range(0, 16383)))),
            int'($urandom_range(0, 7) != 0));
    end
    idle(8);
    chk("drain_empty", 32'(due_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
